// File: rtl/cust_filt_pkg.sv
// Shared types and helpers for the multi-channel IIR filter:
// mode encodings, clear FSM states, saturation and offset-binary helpers.
package cust_filt_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_HP     = 2'b01,
        MODE_LP     = 2'b10,
        MODE_RSVD   = 2'b11
    } filt_mode_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } filt_state_e;

    // Width of the pre-saturation result: hp = x - s/2^C can need 1 extra
    // bit over DATA_W, plus one for sign headroom.
    function automatic int sat_in_w(input int data_w);
        return data_w + 2;
    endfunction

    // Clamp a signed value to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_clip(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Offset binary <-> two's complement: invert the MSB of a w-bit word.
    function automatic logic [63:0] ob_flip(
        input logic [63:0] v,
        input int          w
    );
        return v ^ (64'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/cust_filt_state_ram.sv
// Per-channel filter state register file.
// Ports: clk; one synchronous write port (we/waddr/wdata);
// one combinational read port (raddr/rdata). Out-of-range reads return 0.
module cust_filt_state_ram
    import cust_filt_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/cust_iir_filter_mc.sv
// Multi-channel first-order IIR (bypass / high-pass / low-pass) on an
// interleaved offset-binary stream, 2-stage pipeline with state forwarding.
// Ports: clk, reset; chan_in_{sample,num,valid,read} input stream;
// chan_out_{sample,num,valid,read} output stream; coeff, mode (per transfer);
// clear_state request, busy while the state memory is being zeroed.
module cust_iir_filter_mc
    import cust_filt_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 32,
    parameter int CHAN_W   = 7,
    parameter int COEFF_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  chan_in_sample,
    input  logic [CHAN_W-1:0]  chan_in_num,
    input  logic               chan_in_valid,
    output logic               chan_in_read,
    output logic [DATA_W-1:0]  chan_out_sample,
    output logic [CHAN_W-1:0]  chan_out_num,
    output logic               chan_out_valid,
    input  logic               chan_out_read,
    input  logic [COEFF_W-1:0] coeff,
    input  logic [1:0]         mode,
    input  logic               clear_state,
    output logic               busy
);

    localparam int SW = DATA_W + COEFF_W;
    localparam int DW = SW + 1;
    localparam int PW = DW + COEFF_W + 1;
    localparam int RW = sat_in_w(DATA_W);
    localparam logic [CHAN_W:0] NCH = (CHAN_W+1)'(CHANNELS);

    filt_state_e        st;
    logic [CHAN_W-1:0]  clr_idx;

    logic               stall;
    logic               in_xfer;

    logic               s1_valid;
    logic [DATA_W-1:0]  s1_sample;
    logic [CHAN_W-1:0]  s1_num;
    logic [COEFF_W-1:0] s1_coeff;
    filt_mode_e         s1_mode;
    logic               s1_in_range;

    logic               s2_wr;
    logic signed [SW-1:0] s2_snew;

    logic               ram_we;
    logic [CHAN_W-1:0]  ram_waddr;
    logic [SW-1:0]      ram_wdata;
    logic [SW-1:0]      ram_rdata;

    logic               fwd;
    logic signed [DATA_W-1:0] x;
    logic signed [SW-1:0] s_old;
    logic signed [SW-1:0] s_new;
    logic signed [DW-1:0] xs;
    logic signed [DW-1:0] d;
    logic signed [PW-1:0] prod;
    logic signed [RW-1:0] hp;
    logic signed [RW-1:0] lp;
    logic signed [RW-1:0] res;
    logic [DATA_W-1:0]  y;
    logic [DATA_W-1:0]  out_nxt;

    // Clear/run control; busy is a registered copy of "in CLEAR".
    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= ST_CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
        end else begin
            unique case (st)
                ST_CLEAR: begin
                    if (clear_state) begin
                        clr_idx <= '0;
                    end else if (clr_idx == CHAN_W'(CHANNELS - 1)) begin
                        st   <= ST_RUN;
                        busy <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_state) begin
                        st      <= ST_CLEAR;
                        clr_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    st <= ST_CLEAR;
                end
            endcase
        end
    end

    assign stall        = chan_out_valid & ~chan_out_read;
    assign chan_in_read = (st == ST_RUN) & ~clear_state & ~stall;
    assign in_xfer      = chan_in_valid & chan_in_read;

    // The clear sequence owns the write port; otherwise S2 writes back.
    assign ram_we    = (st == ST_CLEAR) | s2_wr;
    assign ram_waddr = (st == ST_CLEAR) ? clr_idx : chan_out_num;
    assign ram_wdata = (st == ST_CLEAR) ? '0 : s2_snew;

    cust_filt_state_ram #(
        .DEPTH (CHANNELS),
        .WIDTH (SW),
        .AW    (CHAN_W)
    ) u_state_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (s1_num),
        .rdata (ram_rdata)
    );

    assign s1_in_range = {1'b0, s1_num} < NCH;

    // S2 has not written its state yet; take it from the register.
    assign fwd   = s1_in_range & s2_wr & (chan_out_num == s1_num);
    assign s_old = fwd ? s2_snew : $signed(ram_rdata);

    assign x     = DATA_W'(ob_flip(64'(s1_sample), DATA_W));
    assign xs    = {x[DATA_W-1], x, {COEFF_W{1'b0}}};
    assign d     = xs - {s_old[SW-1], s_old};
    assign prod  = PW'(d) * PW'($signed({1'b0, s1_coeff}));
    // Modular add: the true s_new always fits in SW bits.
    assign s_new = s_old + SW'(prod >>> COEFF_W);
    assign hp    = RW'(x) - RW'(s_old >>> COEFF_W);
    assign lp    = RW'(s_new >>> COEFF_W);

    always_comb begin
        res = RW'(x);
        if (s1_in_range) begin
            unique case (s1_mode)
                MODE_HP: res = hp;
                MODE_LP: res = lp;
                default: res = RW'(x);
            endcase
        end
    end

    assign y       = DATA_W'(sat_clip(64'(res), DATA_W));
    assign out_nxt = DATA_W'(ob_flip(64'(y), DATA_W));

    // Both stages advance together; a stall freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid        <= 1'b0;
            s1_sample       <= '0;
            s1_num          <= '0;
            s1_coeff        <= '0;
            s1_mode         <= MODE_BYPASS;
            chan_out_valid  <= 1'b0;
            chan_out_sample <= '0;
            chan_out_num    <= '0;
            s2_wr           <= 1'b0;
            s2_snew         <= '0;
        end else if (!stall) begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_sample <= chan_in_sample;
                s1_num    <= chan_in_num;
                s1_coeff  <= coeff;
                s1_mode   <= filt_mode_e'(mode);
            end
            chan_out_valid <= s1_valid;
            s2_wr <= s1_valid & s1_in_range & (st == ST_RUN);
            if (s1_valid) begin
                chan_out_sample <= out_nxt;
                chan_out_num    <= s1_num;
                s2_snew         <= s_new;
            end
        end else if (st == ST_CLEAR) begin
            // A sample stalled across a clear must not restore old state.
            s2_wr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cust_iir_filter_mc.sv
// Directed bench for cust_iir_filter_mc: vector table with hand-computed
// outputs, scoreboard on the output stream, plus clear/stall/latency cases.
module tb_cust_iir_filter_mc;

    localparam int DATA_W   = 16;
    localparam int CHANNELS = 32;
    localparam int CHAN_W   = 7;
    localparam int COEFF_W  = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [DATA_W-1:0]  chan_in_sample;
    logic [CHAN_W-1:0]  chan_in_num;
    logic               chan_in_valid;
    logic               chan_in_read;
    logic [DATA_W-1:0]  chan_out_sample;
    logic [CHAN_W-1:0]  chan_out_num;
    logic               chan_out_valid;
    logic               chan_out_read;
    logic [COEFF_W-1:0] coeff;
    logic [1:0]         mode;
    logic               clear_state;
    logic               busy;

    typedef struct {
        logic [CHAN_W-1:0]  num;
        logic [DATA_W-1:0]  smp;
        logic [1:0]         mode;
        logic [COEFF_W-1:0] coeff;
        logic [DATA_W-1:0]  exp;
    } vec_t;

    vec_t tbl [$];
    vec_t sb  [$];
    vec_t mon_e;

    int n_chk  = 0;
    int n_fail = 0;

    // HP, coeff 3991, step of +1000: 1000, 940, 882, 829.
    int stp [4] = '{32'h83E8, 32'h83AC, 32'h8372, 32'h833D};

    cust_iir_filter_mc #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS),
        .CHAN_W   (CHAN_W),
        .COEFF_W  (COEFF_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .chan_in_sample  (chan_in_sample),
        .chan_in_num     (chan_in_num),
        .chan_in_valid   (chan_in_valid),
        .chan_in_read    (chan_in_read),
        .chan_out_sample (chan_out_sample),
        .chan_out_num    (chan_out_num),
        .chan_out_valid  (chan_out_valid),
        .chan_out_read   (chan_out_read),
        .coeff           (coeff),
        .mode            (mode),
        .clear_state     (clear_state),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int num, input int smp, input int md,
                                input int cf, input int ex);
        vec_t v;
        v.num   = CHAN_W'(num);
        v.smp   = DATA_W'(smp);
        v.mode  = 2'(md);
        v.coeff = COEFF_W'(cf);
        v.exp   = DATA_W'(ex);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && chan_out_valid && chan_out_read) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL extra_output: got %0h on ch %0d, expected none",
                         chan_out_sample, chan_out_num);
            end else begin
                mon_e = sb.pop_front();
                chk("out_sample", 32'(chan_out_sample), 32'(mon_e.exp));
                chk("out_num", 32'(chan_out_num), 32'(mon_e.num));
            end
        end
    end

    task automatic send(input vec_t t);
        int k;
        chan_in_valid  = 1'b1;
        chan_in_sample = t.smp;
        chan_in_num    = t.num;
        mode           = t.mode;
        coeff          = t.coeff;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (chan_in_read) break;
        end
        if (k >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_accept: got no chan_in_read, expected 1");
        end else begin
            sb.push_back(t);
        end
        @(posedge clk);
        #1;
        chan_in_valid = 1'b0;
    endtask

    task automatic send_range(input int a, input int b);
        for (int i = a; i <= b; i++) send(tbl[i]);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_missing", 32'(sb.size()), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_state = 1'b1;
        @(posedge clk);
        #1;
        clear_state = 1'b0;
    endtask

    task automatic count_busy(output int n, output int rd, output int ra);
        n  = 0;
        rd = 0;
        ra = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ra = int'(chan_in_read);
                break;
            end
            n++;
            if (chan_in_read) rd++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    initial begin
        int n, m, rd, ra;

        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 32'h83E8, 1, 3991, stp[k]));
        tbl.push_back(mk(0, 32'h83E8, 1, 3991, 32'h83E8));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(0, 32'h83E8, 1, 3991, stp[k]));
            tbl.push_back(mk(1, 32'h8000, 1, 3991, 32'h8000));
            tbl.push_back(mk(2, 32'h83E8, 1, 3991, stp[k]));
        end
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(0, 32'h83E8, 1, 3991, stp[k]));
            tbl.push_back(mk(2, 32'h83E8, 1, 3991, stp[k]));
        end
        tbl.push_back(mk(3, 32'h0000, 1, 65535, 32'h0000));
        tbl.push_back(mk(3, 32'h0000, 1, 65535, 32'h8000));
        tbl.push_back(mk(3, 32'hFFFF, 1, 65535, 32'hFFFF));
        tbl.push_back(mk(4, 32'h1234, 0, 3991, 32'h1234));
        tbl.push_back(mk(4, 32'hABCD, 3, 3991, 32'hABCD));
        tbl.push_back(mk(5, 32'h83E8, 2, 32768, 32'h81F4));
        tbl.push_back(mk(5, 32'h83E8, 2, 32768, 32'h82EE));
        tbl.push_back(mk(40, 32'h83E8, 1, 3991, 32'h83E8));
        tbl.push_back(mk(40, 32'h83E8, 1, 3991, 32'h83E8));
        tbl.push_back(mk(8, 32'h83E8, 1, 3991, 32'h83E8));

        reset          = 1'b1;
        chan_in_valid  = 1'b0;
        chan_in_sample = '0;
        chan_in_num    = '0;
        chan_out_read  = 1'b1;
        coeff          = '0;
        mode           = '0;
        clear_state    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(chan_out_valid), 0);
        chk("rst_out_sample", 32'(chan_out_sample), 0);
        chk("rst_out_num", 32'(chan_out_num), 0);
        chk("rst_in_read", 32'(chan_in_read), 0);
        chk("rst_busy", 32'(busy), 1);
        reset = 1'b0;

        count_busy(n, rd, ra);
        chk("reset_busy_cycles", 32'(n), 32);
        chk("reset_read_in_clear", 32'(rd), 0);
        chk("reset_read_after", 32'(ra), 1);

        send_range(0, 3);
        drain();

        pulse_clear();
        count_busy(n, rd, ra);
        chk("clear_busy_cycles", 32'(n), 32);
        chk("clear_read_in_clear", 32'(rd), 0);
        send_range(4, 4);
        drain();

        pulse_clear();
        n = 0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (busy) n++;
            if (i == 10) clear_state = 1'b1;
        end
        @(posedge clk);
        #1;
        clear_state = 1'b0;
        count_busy(m, rd, ra);
        chk("restart_busy_cycles", 32'(n + m), 43);

        send_range(5, 16);
        drain();

        pulse_clear();
        count_busy(n, rd, ra);
        fork
            send_range(17, 24);
            begin
                repeat (4) @(posedge clk);
                #1;
                chan_out_read = 1'b0;
                @(negedge clk);
                chk("stall_in_read", 32'(chan_in_read), 0);
                chk("stall_out_valid", 32'(chan_out_valid), 1);
                repeat (5) @(posedge clk);
                #1;
                chan_out_read = 1'b1;
            end
        join
        drain();

        send_range(25, 27);
        drain();

        send(tbl[28]);
        @(negedge clk);
        chk("latency_cycle1", 32'(chan_out_valid), 0);
        @(negedge clk);
        chk("latency_cycle2", 32'(chan_out_valid), 1);
        drain();

        send_range(29, 34);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
